slot_alloc_ctrl: RTL and testbench

//  Allocation/flush controller for a 64-entry one-hot-addressed resource (cache lines, tags, buffers).

---
 rtl/slot_alloc_if.sv | 39 +++
 rtl/slot_alloc_ctrl.sv | 124 ++++++++++++
 tb/tb_slot_alloc_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/slot_alloc_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slot_alloc_if : allocate / free / flush write-back bundle for slot_alloc_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
interface slot_alloc_if #(
  parameter int IDX_W   = 6,
  parameter int N_SLOTS = 64
);
  logic               alloc_req;
  logic               alloc_gnt;
  logic [IDX_W-1:0]   alloc_idx;
  logic               free_valid;
  logic [IDX_W-1:0]   free_idx;
  logic               free_err;
  logic               flush_req;
  logic               wb_valid;
  logic [IDX_W-1:0]   wb_idx;
  logic               wb_ready;
  logic               flush_busy;
  logic               flush_done;
  logic [N_SLOTS-1:0] busy_vec;
  logic [IDX_W:0]     count;
  logic               full;
  logic               empty;

  modport slave (
    input  alloc_req, free_valid, free_idx, flush_req, wb_ready,
    output alloc_gnt, alloc_idx, free_err, wb_valid, wb_idx,
           flush_busy, flush_done, busy_vec, count, full, empty
  );

  modport master (
    output alloc_req, free_valid, free_idx, flush_req, wb_ready,
    input  alloc_gnt, alloc_idx, free_err, wb_valid, wb_idx,
           flush_busy, flush_done, busy_vec, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/slot_alloc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slot_alloc_ctrl : lowest-free slot allocator with busy tracking and write-back flush walk
// Rev 1.0
// ----------------------------------------------------------------------------
module slot_alloc_ctrl #(
  parameter int IDX_W   = 6,
  parameter int N_SLOTS = 64
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  slot_alloc_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_SLOTS - 1);
  localparam logic [IDX_W:0]   C_FULL = (IDX_W + 1)'(N_SLOTS);

  logic [1:0]         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [N_SLOTS-1:0] r_busy, w_busy_nxt;
  logic [IDX_W:0]     r_count, w_count_nxt;
  logic               r_full, r_empty, r_free_err;
  logic [IDX_W-1:0]   w_low_free;
  logic               w_gnt, w_wb_valid, w_wb_fire, w_step;

  // Searching from the top down leaves the lowest free index as the final winner.
  always_comb begin
    w_low_free = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_low_free = IDX_W'(i);
    end
  end

  assign w_gnt      = bus.alloc_req & ~r_full & (r_state == ST_RUN);
  assign w_wb_valid = (r_state == ST_FLUSH) & r_busy[r_ptr];
  assign w_wb_fire  = w_wb_valid & bus.wb_ready;
  assign w_step     = ~r_busy[r_ptr] | bus.wb_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_RUN: begin
        w_ptr_nxt = '0;
        if (bus.flush_req) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_step) begin
          if (r_ptr == C_LAST) w_state_nxt = ST_DONE;
          else                 w_ptr_nxt   = r_ptr + IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_RUN;
        w_ptr_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Grant is applied last so a granted slot wins over a stray free aimed at it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.free_valid) w_busy_nxt[bus.free_idx] = 1'b0;
    if (w_wb_fire)      w_busy_nxt[r_ptr]        = 1'b0;
    if (w_gnt)          w_busy_nxt[w_low_free]   = 1'b1;
    w_count_nxt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_count_nxt = w_count_nxt + (IDX_W + 1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_free_err <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == C_FULL);
      r_empty    <= (w_count_nxt == '0);
      r_free_err <= bus.free_valid & ~r_busy[bus.free_idx];
    end
  end

  // Output logic
  always_comb begin
    bus.alloc_gnt  = w_gnt;
    bus.alloc_idx  = w_low_free;
    bus.free_err   = r_free_err;
    bus.wb_valid   = w_wb_valid;
    bus.wb_idx     = r_ptr;
    bus.flush_busy = (r_state == ST_FLUSH);
    bus.flush_done = (r_state == ST_DONE);
    bus.busy_vec   = r_busy;
    bus.count      = r_count;
    bus.full       = r_full;
    bus.empty      = r_empty;
  end

endmodule
`default_nettype wire

// File: tb/tb_slot_alloc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_slot_alloc_ctrl : directed scenarios plus random traffic against a slot-set reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_slot_alloc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slot_alloc_if #(.IDX_W(6), .N_SLOTS(64)) bus ();

  slot_alloc_ctrl #(.IDX_W(6), .N_SLOTS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: set of busy slots, flush mode (0 run, 1 walking, 2 done), walk pointer.
  logic [63:0] m_busy;
  int          m_mode;
  int          m_ptr;
  bit          m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit req, input bit fv, input int fidx, input bit frq, input bit rdy);
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_idx   = 6'(fidx);
    bus.flush_req  = frq;
    bus.wb_ready   = rdy;
  endtask

  // Check all outputs mid-cycle, then advance the model and the DUT by one clock.
  task automatic step();
    int          cnt, low, nptr, nmode;
    bit          gnt, wbv;
    logic [63:0] nb;
    @(negedge clk);
    cnt = $countones(m_busy);
    low = 0;
    for (int i = 63; i >= 0; i--) if (!m_busy[i]) low = i;
    gnt = (bus.alloc_req === 1'b1) && (cnt < 64) && (m_mode == 0);
    wbv = (m_mode == 1) && m_busy[m_ptr];
    chk("alloc_gnt", bus.alloc_gnt, gnt);
    chk("alloc_idx", bus.alloc_idx, low);
    chk("wb_valid", bus.wb_valid, wbv);
    if (wbv) chk("wb_idx", bus.wb_idx, m_ptr);
    chk("flush_busy", bus.flush_busy, m_mode == 1);
    chk("flush_done", bus.flush_done, m_mode == 2);
    chk("busy_vec", bus.busy_vec, m_busy);
    chk("count", bus.count, cnt);
    chk("full", bus.full, cnt == 64);
    chk("empty", bus.empty, cnt == 0);
    chk("free_err", bus.free_err, m_err);

    nb = m_busy;
    if (bus.free_valid) nb[bus.free_idx] = 1'b0;
    if (wbv && bus.wb_ready) nb[m_ptr] = 1'b0;
    if (gnt) nb[low] = 1'b1;
    nmode = m_mode;
    nptr  = m_ptr;
    if (m_mode == 0) begin
      nptr = 0;
      if (bus.flush_req) nmode = 1;
    end else if (m_mode == 1) begin
      if (!m_busy[m_ptr] || bus.wb_ready) begin
        if (m_ptr == 63) nmode = 2;
        else             nptr  = m_ptr + 1;
      end
    end else begin
      nmode = 0;
      nptr  = 0;
    end
    m_err = bus.free_valid && !m_busy[bus.free_idx];

    @(posedge clk);
    #1;
    m_busy = nb;
    m_mode = nmode;
    m_ptr  = nptr;
  endtask

  // Asserted a little after a rising edge; effects must appear without waiting for a clock.
  task automatic hard_reset();
    drive(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_vec", bus.busy_vec, 64'd0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_gnt", bus.alloc_gnt, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_flush_busy", bus.flush_busy, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    chk("rst_free_err", bus.free_err, 0);
    m_busy = '0;
    m_mode = 0;
    m_ptr  = 0;
    m_err  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // 1: fill in order, then one refused request
    hard_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 0, 0, 0);
      step();
    end
    chk("t1_count", bus.count, 64);
    chk("t1_full", bus.full, 1);
    drive(1, 0, 0, 0, 0);
    step();

    // 2: holes at 17 and 40 refilled lowest first
    drive(0, 1, 17, 0, 0); step();
    drive(0, 1, 40, 0, 0); step();
    drive(1, 0, 0, 0, 0);
    #1 chk("t2_first", bus.alloc_idx, 17);
    step();
    #1 chk("t2_second", bus.alloc_idx, 40);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t2_count", bus.count, 64);
    chk("t2_empty", bus.empty, 0);

    // 3: slot being freed is not granted in the same cycle
    hard_reset();
    for (int i = 0; i < 6; i++) begin drive(1, 0, 0, 0, 0); step(); end
    for (int i = 0; i < 5; i++) begin drive(0, 1, i, 0, 0); step(); end
    drive(1, 1, 5, 0, 0);
    #1 chk("t3_idx", bus.alloc_idx, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t3_busy", bus.busy_vec, 64'd1);
    chk("t3_count", bus.count, 1);

    // 4: free of an idle slot
    drive(0, 1, 9, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    chk("t4_err", bus.free_err, 1);
    chk("t4_busy", bus.busy_vec, 64'd1);
    step();

    // 5: flush with busy={3,62} and a 4-cycle stall on slot 3
    hard_reset();
    for (int i = 0; i < 63; i++) begin drive(1, 0, 0, 0, 0); step(); end
    for (int i = 0; i < 62; i++) begin
      if (i != 3) begin drive(0, 1, i, 0, 0); step(); end
    end
    drive(0, 0, 0, 1, 0); step();
    drive(1, 0, 0, 0, 0);
    n = 0;
    while (bus.wb_valid !== 1'b1 && n < 100) begin step(); n++; end
    chk("t5_reach3", n < 100, 1);
    chk("t5_wb3", bus.wb_idx, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_stall_idx", bus.wb_idx, 3);
      chk("t5_stall_gnt", bus.alloc_gnt, 0);
    end
    drive(1, 0, 0, 0, 1);
    n = 0;
    while (bus.flush_done !== 1'b1 && n < 100) begin
      if (bus.wb_valid === 1'b1) chk("t5_wb62", bus.wb_idx, (n == 0) ? 3 : 62);
      step();
      n++;
    end
    chk("t5_done_seen", n < 100, 1);
    drive(0, 0, 0, 0, 0);
    chk("t5_empty", bus.empty, 1);
    step();

    // 6: reset in the middle of a full flush
    hard_reset();
    for (int i = 0; i < 64; i++) begin drive(1, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 1);
    n = 0;
    while (!(bus.wb_valid === 1'b1 && bus.wb_idx == 6'd30) && n < 100) begin step(); n++; end
    chk("t6_reach30", n < 100, 1);
    hard_reset();
    drive(1, 0, 0, 0, 0);
    #1 chk("t6_gnt", bus.alloc_gnt, 1);
    chk("t6_idx", bus.alloc_idx, 0);
    step();

    // Random traffic
    hard_reset();
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 63),
            $urandom_range(0, 99) < 2, $urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
